stm32_bus_master: RTL and testbench

- Initiator end of the 8-bit DATA_BUS / DATA_SYNC parallel link. It performs the STM32-side transactions: it issues a command byte with DATA_SYNC, then writes or reads a fixed number of payload bytes, one per clock.
- Uses: on-board host emulation, bus self-test, and the simulation driver for the FPGA-side responder.
- Transaction interface toward the user logic: a command port, a write-byte stream and a read-byte stream.

---
 rtl/stm32_bus_master_pkg.sv | 29 ++
 rtl/stm32_bus_master.sv | 142 ++++++++++++++
 tb/tb_stm32_bus_master.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stm32_bus_master_pkg.sv
// Shared definitions for the STM32 DATA_BUS / DATA_SYNC link: command codes, payload lengths, FSM states.
package stm32_bus_pkg;

  localparam logic [7:0] CMD_BUS_TEST    = 8'd0;
  localparam logic [7:0] CMD_GET_PARAMS  = 8'd1;
  localparam logic [7:0] CMD_SEND_PARAMS = 8'd2;
  localparam logic [7:0] CMD_TX_IQ       = 8'd3;
  localparam logic [7:0] CMD_RX_IQ       = 8'd4;
  localparam logic [7:0] CMD_RESET_ON    = 8'd5;
  localparam logic [7:0] CMD_RESET_OFF   = 8'd6;
  localparam logic [7:0] CMD_FLASH       = 8'd7;
  localparam logic [7:0] CMD_GET_INFO    = 8'd8;

  localparam int unsigned GET_PARAMS_LEN  = 20;
  localparam int unsigned SEND_PARAMS_LEN = 8;
  localparam int unsigned TX_IQ_LEN       = 8;
  localparam int unsigned RX_IQ_LEN       = 8;
  localparam int unsigned INFO_LEN        = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_WRITE,
    ST_TURN,
    ST_READ,
    ST_FIN
  } state_t;

endpackage

// File: rtl/stm32_bus_master.sv
// Initiator end of the DATA_BUS / DATA_SYNC link: command byte with sync, then fixed-length write or read payload.
// Optional payload XOR checksum enabled by defining STM32_BUS_MASTER_CHECKSUM_EN.
module stm32_bus_master
  import stm32_bus_pkg::*;
#(
  parameter int unsigned MAX_LEN = 255,
  parameter int unsigned LEN_W   = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_code,
  input  logic             cmd_dir,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             underrun,
  output logic [7:0]       checksum,
  output logic             data_sync,
  output logic [7:0]       bus_data_out,
  output logic             bus_oe,
  input  logic [7:0]       bus_data_in
);

  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             dir_q;
  logic             accept;
  logic             load;
  logic             capture;
  logic [7:0]       tx_byte;
  logic [LEN_W-1:0] len_clamped;

  assign cmd_ready   = (state_q == ST_IDLE);
  assign wr_ready    = load;
  assign tx_byte     = wr_valid ? wr_data : '0;
  assign len_clamped = (cmd_len > MAX_LEN_L) ? MAX_LEN_L : cmd_len;

  // load: a write byte is due at the closing edge of this cycle (byte 0 at the end of SYNC).
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (len_q == '0) begin
          state_d = ST_FIN;
        end else if (!dir_q) begin
          load    = 1'b1;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_TURN;
        end
      end
      ST_WRITE: begin
        if (cnt_q == len_q) state_d = ST_FIN;
        else                load    = 1'b1;
      end
      ST_TURN: state_d = ST_READ;
      ST_READ: begin
        capture = 1'b1;
        if (cnt_q == len_q - ONE) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      data_sync    <= 1'b0;
      bus_oe       <= 1'b0;
      bus_data_out <= '0;
      done         <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      underrun     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_sync <= (state_d == ST_SYNC);
      bus_oe    <= (state_d == ST_SYNC) || (state_d == ST_WRITE);
      done      <= (state_d == ST_FIN);
      rd_valid  <= capture;
      if (accept) begin
        len_q        <= len_clamped;
        dir_q        <= cmd_dir;
        cnt_q        <= '0;
        underrun     <= 1'b0;
        bus_data_out <= cmd_code;
      end
      if (load) begin
        bus_data_out <= tx_byte;
        cnt_q        <= cnt_q + ONE;
        if (!wr_valid) underrun <= 1'b1;
      end
      if (capture) begin
        rd_data <= bus_data_in;
        cnt_q   <= cnt_q + ONE;
      end
    end
  end

`ifdef STM32_BUS_MASTER_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk_in) begin
    if (reset || accept) begin
      sum_q <= '0;
    end else if (load) begin
      sum_q <= sum_q ^ tx_byte;
    end else if (capture) begin
      sum_q <= sum_q ^ bus_data_in;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_stm32_bus_master.sv
// Self-checking bench for stm32_bus_master: vector table, hand-written corner sequences and random transactions.
module tb_stm32_bus_master;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_code;
  logic       cmd_dir;
  logic [7:0] cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       underrun;
  logic [7:0] checksum;
  logic       data_sync;
  logic [7:0] bus_data_out;
  logic       bus_oe;
  logic [7:0] bus_data_in;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0] pay  [0:255];
  bit         drop [0:255];
  logic [7:0] last_sum;

  always #5 clk_in = ~clk_in;

  stm32_bus_master #(.MAX_LEN(255), .LEN_W(8)) dut (
    .clk_in(clk_in), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_dir(cmd_dir), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .underrun(underrun), .checksum(checksum),
    .data_sync(data_sync), .bus_data_out(bus_data_out), .bus_oe(bus_oe),
    .bus_data_in(bus_data_in)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Reference rules: latency, underrun and XOR computed straight from the transaction description.
  function automatic int unsigned model_lat(input logic dir, input int unsigned len);
    if (len == 0) return 2;
    return dir ? len + 3 : len + 2;
  endfunction

  function automatic bit model_under(input logic dir, input int unsigned len);
    bit u = 1'b0;
    if (!dir) for (int unsigned i = 0; i < len; i++) if (drop[i]) u = 1'b1;
    return u;
  endfunction

  function automatic logic [7:0] model_byte(input logic dir, input int unsigned i);
    return (!dir && drop[i]) ? 8'h00 : pay[i];
  endfunction

  function automatic logic [7:0] model_sum(input logic dir, input int unsigned len);
    logic [7:0] s = '0;
`ifdef STM32_BUS_MASTER_CHECKSUM_EN
    for (int unsigned i = 0; i < len; i++) s ^= model_byte(dir, i);
`endif
    return s;
  endfunction

  task automatic drive_inputs(input int unsigned c, input int unsigned pos, input logic dir,
                              input int unsigned len, input int unsigned nsync, input int unsigned sync_cyc);
    cmd_valid = (c == 2);
    cmd_code  = 8'($urandom);
    cmd_dir   = 1'($urandom);
    cmd_len   = 8'($urandom);
    if (pos < len && !drop[pos]) begin
      wr_valid = 1'b1;
      wr_data  = pay[pos];
    end else begin
      wr_valid = (pos < len) ? 1'b0 : 1'($urandom);
      wr_data  = 8'($urandom);
    end
    // Responder: byte i visible during the cycle starting two edges after the sync cycle ends.
    if (dir && nsync != 0 && c >= sync_cyc + 2 && c - (sync_cyc + 2) < len)
      bus_data_in = pay[c - (sync_cyc + 2)];
    else
      bus_data_in = 8'($urandom);
  endtask

  task automatic run_txn(input string nm, input logic [7:0] code, input logic dir,
                         input int unsigned len, input int unsigned exp_lat, input bit exp_under);
    int unsigned pos = 0, nsync = 0, sync_cyc = 0, noe = 0, nrd = 0, first_rd = 0;
    logic [31:0] done_cyc = 32'hFFFF_FFFF;
    logic [7:0]  sync_bus = 'x;
    logic [7:0]  bus_q[$];
    logic [7:0]  rd_q[$];
    logic        under_at_done = 'x;
    logic [7:0]  sum_at_done = 'x;
    bit          got_done = 1'b0, finished = 1'b0;

    @(posedge clk_in); #1;
    drive_inputs(0, 0, dir, len, 0, 0);
    cmd_valid = 1'b1; cmd_code = code; cmd_dir = dir; cmd_len = 8'(len);
    for (int unsigned cyc = 0; cyc < exp_lat + 12 && !finished; cyc++) begin
      @(negedge clk_in);
      if (cyc == 0) chk({nm, ":ready_idle"}, 32'(cmd_ready), 1);
      if (cyc == 1) begin
        chk({nm, ":ready_busy"}, 32'(cmd_ready), 0);
        chk({nm, ":under_clr"}, 32'(underrun), 0);
      end
      if (data_sync) begin nsync++; sync_cyc = cyc; sync_bus = bus_data_out; end
      if (bus_oe) noe++;
      if (bus_oe && !data_sync) bus_q.push_back(bus_data_out);
      if (rd_valid) begin if (nrd == 0) first_rd = cyc; nrd++; rd_q.push_back(rd_data); end
      if (wr_ready) pos++;
      if (got_done) begin
        chk({nm, ":done_width"}, 32'(done), 0);
        chk({nm, ":ready_after"}, 32'(cmd_ready), 1);
        finished = 1'b1;
      end else if (done) begin
        got_done = 1'b1; done_cyc = cyc; under_at_done = underrun; sum_at_done = checksum;
      end
      @(posedge clk_in); #1;
      drive_inputs(cyc + 1, pos, dir, len, nsync, sync_cyc);
    end
    cmd_valid = 1'b0;
    last_sum  = sum_at_done;

    chk({nm, ":done_seen"}, 32'(finished), 1);
    chk({nm, ":sync_cnt"}, nsync, 1);
    chk({nm, ":sync_cyc"}, sync_cyc, 1);
    chk({nm, ":sync_bus"}, 32'(sync_bus), 32'(code));
    chk({nm, ":done_cyc"}, done_cyc, exp_lat);
    chk({nm, ":oe_cycles"}, noe, (dir || len == 0) ? 1 : len + 1);
    chk({nm, ":wr_ready_n"}, pos, dir ? 0 : len);
    chk({nm, ":bus_n"}, bus_q.size(), dir ? 0 : len);
    chk({nm, ":rd_n"}, rd_q.size(), dir ? len : 0);
    for (int unsigned i = 0; i < bus_q.size() && i < len; i++)
      chk($sformatf("%s:bus[%0d]", nm, i), 32'(bus_q[i]), 32'(model_byte(dir, i)));
    for (int unsigned i = 0; i < rd_q.size() && i < len; i++)
      chk($sformatf("%s:rd[%0d]", nm, i), 32'(rd_q[i]), 32'(pay[i]));
    if (dir && len != 0) chk({nm, ":first_rd"}, first_rd, 4);
    chk({nm, ":underrun"}, 32'(under_at_done), 32'(exp_under));
    chk({nm, ":checksum"}, 32'(sum_at_done), 32'(model_sum(dir, len)));
  endtask

  typedef struct {
    logic [7:0]  code;
    logic        dir;
    int unsigned len;
    logic [7:0]  base;
    int          drop_at;
    int unsigned lat;
    bit          under;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[7];
    int unsigned dones;

    vecs[0] = '{8'd1, 1'b0, 20, 8'h01, -1, 22, 1'b0};
    vecs[1] = '{8'd2, 1'b1,  8, 8'hA0, -1, 11, 1'b0};
    vecs[2] = '{8'd5, 1'b0,  0, 8'h00, -1,  2, 1'b0};
    vecs[3] = '{8'd3, 1'b0,  8, 8'h30,  3, 10, 1'b1};
    vecs[4] = '{8'd8, 1'b1,  3, 8'h51, -1,  6, 1'b0};
    vecs[5] = '{8'd0, 1'b0,  1, 8'hEE, -1,  3, 1'b0};
    vecs[6] = '{8'd4, 1'b1,  1, 8'h7F, -1,  4, 1'b0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_code = '0; cmd_dir = 1'b0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; bus_data_in = '0;
    repeat (3) @(posedge clk_in);
    #1 reset = 1'b0;
    @(negedge clk_in);
    chk("rst:data_sync", 32'(data_sync), 0);
    chk("rst:bus_oe", 32'(bus_oe), 0);
    chk("rst:bus_data_out", 32'(bus_data_out), 0);
    chk("rst:rd_valid", 32'(rd_valid), 0);
    chk("rst:done", 32'(done), 0);
    chk("rst:underrun", 32'(underrun), 0);
    chk("rst:checksum", 32'(checksum), 0);
    chk("rst:wr_ready", 32'(wr_ready), 0);
    chk("rst:cmd_ready", 32'(cmd_ready), 1);

    for (int unsigned v = 0; v < 7; v++) begin
      for (int unsigned i = 0; i < 256; i++) begin
        pay[i]  = 8'(vecs[v].base + 8'(i));
        drop[i] = (int'(i) == vecs[v].drop_at);
      end
      run_txn($sformatf("vec%0d", v), vecs[v].code, vecs[v].dir, vecs[v].len,
              vecs[v].lat, vecs[v].under);
    end

    // Checksum over a read of 0x0F, 0xF0, 0x33.
    for (int unsigned i = 0; i < 256; i++) drop[i] = 1'b0;
    pay[0] = 8'h0F; pay[1] = 8'hF0; pay[2] = 8'h33;
    run_txn("cks_read", 8'd4, 1'b1, 3, 6, 1'b0);
`ifdef STM32_BUS_MASTER_CHECKSUM_EN
    chk("cks_value", 32'(last_sum), 32'h0000_00CC);
`else
    chk("cks_value", 32'(last_sum), 32'h0000_0000);
`endif

    // Reset while byte 4 of an 8-byte read is on the bus (cycle 7 after accept).
    for (int unsigned i = 0; i < 8; i++) pay[i] = 8'(8'hA0 + 8'(i));
    @(posedge clk_in); #1;
    cmd_valid = 1'b1; cmd_code = 8'd4; cmd_dir = 1'b1; cmd_len = 8'd8;
    @(posedge clk_in); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    chk("rstmid:oe_in_read", 32'(bus_oe), 0);
    @(posedge clk_in); #1;
    reset = 1'b1;
    @(posedge clk_in); #1;
    reset = 1'b0;
    @(negedge clk_in);
    chk("rstmid:bus_oe", 32'(bus_oe), 0);
    chk("rstmid:data_sync", 32'(data_sync), 0);
    chk("rstmid:done", 32'(done), 0);
    chk("rstmid:rd_valid", 32'(rd_valid), 0);
    chk("rstmid:cmd_ready", 32'(cmd_ready), 1);
    dones = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (done) dones++;
    end
    chk("rstmid:no_done", dones, 0);
    for (int unsigned i = 0; i < 4; i++) begin pay[i] = 8'(8'h11 * (i + 1)); drop[i] = 1'b0; end
    run_txn("rstmid:post_write", 8'd0, 1'b0, 4, 6, 1'b0);

    // Random transactions against the reference rules.
    for (int unsigned t = 0; t < 40; t++) begin
      logic [7:0]  code;
      logic        dir;
      int unsigned len;
      code = 8'($urandom_range(0, 8));
      dir  = 1'($urandom);
      len  = $urandom_range(0, 24);
      for (int unsigned i = 0; i < 256; i++) begin
        pay[i]  = 8'($urandom);
        drop[i] = ($urandom_range(0, 7) == 0);
      end
      run_txn($sformatf("rnd%0d", t), code, dir, len, model_lat(dir, len), model_under(dir, len));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
